can_frame_tx_fsm: RTL and testbench

- Transmit-side counterpart of the receive protocol FSM. Serializes one classic CAN 2.0 frame onto tx_o, one bit per tx_point_i. Supports base and extended IDs, data and remote frames.
- Performs bit stuffing, CRC-15 generation, and arbitration/bit/ACK monitoring against sampled_bit_i.
- Sits between the TX buffer registers and the bus line driver, sharing bit timing with the receiver.

---
 rtl/can_frame_tx_fsm_pkg.sv | 35 +++
 rtl/can_frame_tx_fsm_if.sv | 31 +++
 rtl/can_frame_tx_fsm_crc15.sv | 28 ++
 rtl/can_frame_tx_fsm.sv | 195 +++++++++++++++++++
 tb/tb_can_frame_tx_fsm.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/can_frame_tx_fsm_pkg.sv
// Shared types and constants for the CAN 2.0 transmit frame FSM and its CRC helper.
package can_tx_pkg;

    typedef enum logic [3:0] {
        TX_IDLE,
        TX_SOF,
        TX_ID_A,
        TX_SRR_RTR,
        TX_IDE,
        TX_ID_B,
        TX_RTR,
        TX_R1,
        TX_R0,
        TX_DLC,
        TX_DATA,
        TX_CRC,
        TX_CRC_DEL,
        TX_ACK,
        TX_ACK_DEL,
        TX_EOF
    } can_tx_state_t;

    localparam logic [14:0] CRC15_POLY = 15'h4599;
    localparam int ID_A_LEN = 11;
    localparam int ID_B_LEN = 18;
    localparam int DLC_LEN  = 4;
    localparam int CRC_LEN  = 15;

    function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[14];
        return {crc[13:0], 1'b0} ^ (fb ? CRC15_POLY : 15'h0000);
    endfunction

endpackage

// File: rtl/can_frame_tx_fsm_if.sv
// Bit-timing, TX-buffer and status signals between the transmit FSM and its surroundings.
interface can_frame_tx_fsm_if;
    logic        tx_point_i;
    logic        sample_point_i;
    logic        sampled_bit_i;
    logic        bus_idle_i;
    logic        tx_request_i;
    logic        ide_i;
    logic        rtr_i;
    logic [28:0] id_i;
    logic [3:0]  dlc_i;
    logic [63:0] data_i;
    logic        tx_o;
    logic        tx_busy_o;
    logic        tx_done_o;
    logic        arb_lost_o;
    logic        bit_err_o;
    logic        ack_err_o;

    modport master (
        output tx_point_i, sample_point_i, sampled_bit_i, bus_idle_i, tx_request_i,
               ide_i, rtr_i, id_i, dlc_i, data_i,
        input  tx_o, tx_busy_o, tx_done_o, arb_lost_o, bit_err_o, ack_err_o
    );

    modport slave (
        input  tx_point_i, sample_point_i, sampled_bit_i, bus_idle_i, tx_request_i,
               ide_i, rtr_i, id_i, dlc_i, data_i,
        output tx_o, tx_busy_o, tx_done_o, arb_lost_o, bit_err_o, ack_err_o
    );
endinterface

// File: rtl/can_frame_tx_fsm_crc15.sv
// Serial CAN CRC-15; clear and enable together restart the CRC with the given bit.
module can_crc15_gen
    import can_tx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic        bit_i,
    output logic [14:0] crc_o
);
    logic [14:0] r_crc;
    logic [14:0] w_base;

    assign w_base = clear_i ? 15'h0000 : r_crc;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_crc <= 15'h0000;
        end else if (enable_i) begin
            r_crc <= crc15_step(w_base, bit_i);
        end else if (clear_i) begin
            r_crc <= 15'h0000;
        end
    end

    assign crc_o = r_crc;
endmodule

// File: rtl/can_frame_tx_fsm.sv
// CAN 2.0 frame serializer: stuffing, CRC-15, arbitration / bit / ACK monitoring.
// State and counter always describe the bit currently on tx_o; r_stuff marks a stuff bit.
module can_frame_tx_fsm
    import can_tx_pkg::*;
#(
    parameter int STUFF_LEN = 5,
    parameter int EOF_LEN   = 7
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    can_frame_tx_fsm_if.slave tx_if
);
    localparam logic [5:0] ID_A_LAST = 6'(ID_A_LEN - 1);
    localparam logic [5:0] ID_B_LAST = 6'(ID_B_LEN - 1);
    localparam logic [5:0] DLC_LAST  = 6'(DLC_LEN - 1);
    localparam logic [5:0] CRC_LAST  = 6'(CRC_LEN - 1);
    localparam logic [5:0] EOF_LAST  = 6'(EOF_LEN - 1);
    localparam logic [3:0] STUFF_RUN = 4'(STUFF_LEN);

    can_tx_state_t r_state, w_nxt_state;
    logic [5:0]  r_cnt, w_nxt_cnt;
    logic        r_tx, r_busy, r_stuff, r_last;
    logic [3:0]  r_run;
    logic        r_ide, r_rtr;
    logic [3:0]  r_dlc;
    logic [10:0] r_id_a_sh;
    logic [17:0] r_id_b_sh;
    logic [3:0]  r_dlc_sh;
    logic [63:0] r_data_sh;
    logic [14:0] r_crc_sh;
    logic        r_done, r_arb, r_bit_err, r_ack_err;

    logic [14:0] w_crc;
    logic        w_nxt_bit, w_start, w_stuff_due, w_do_stuff, w_advance, w_crc_en, w_crc_bit;
    logic [3:0]  w_bytes;
    logic [2:0]  w_bytes_m1;
    logic [5:0]  w_data_last;
    logic        w_no_data, w_sample, w_mismatch, w_in_arb;
    logic        w_arb_lost, w_ack_err, w_bit_err, w_done;

    assign w_bytes     = r_rtr ? 4'd0 : ((r_dlc > 4'd8) ? 4'd8 : r_dlc);
    assign w_bytes_m1  = 3'(w_bytes - 4'd1);
    assign w_data_last = {w_bytes_m1, 3'b111};
    assign w_no_data   = (w_bytes == 4'd0);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = 6'd0;
        case (r_state)
            TX_SOF:     w_nxt_state = TX_ID_A;
            TX_ID_A:    if (r_cnt == ID_A_LAST) w_nxt_state = TX_SRR_RTR; else w_nxt_cnt = r_cnt + 6'd1;
            TX_SRR_RTR: w_nxt_state = TX_IDE;
            TX_IDE:     w_nxt_state = r_ide ? TX_ID_B : TX_R0;
            TX_ID_B:    if (r_cnt == ID_B_LAST) w_nxt_state = TX_RTR; else w_nxt_cnt = r_cnt + 6'd1;
            TX_RTR:     w_nxt_state = TX_R1;
            TX_R1:      w_nxt_state = TX_R0;
            TX_R0:      w_nxt_state = TX_DLC;
            TX_DLC:     if (r_cnt == DLC_LAST) w_nxt_state = w_no_data ? TX_CRC : TX_DATA;
                        else w_nxt_cnt = r_cnt + 6'd1;
            TX_DATA:    if (r_cnt == w_data_last) w_nxt_state = TX_CRC; else w_nxt_cnt = r_cnt + 6'd1;
            TX_CRC:     if (r_cnt == CRC_LAST) w_nxt_state = TX_CRC_DEL; else w_nxt_cnt = r_cnt + 6'd1;
            TX_CRC_DEL: w_nxt_state = TX_ACK;
            TX_ACK:     w_nxt_state = TX_ACK_DEL;
            TX_ACK_DEL: w_nxt_state = TX_EOF;
            TX_EOF:     w_nxt_cnt = (r_cnt == EOF_LAST) ? r_cnt : r_cnt + 6'd1;
            default:    ;
        endcase
    end

    // Each field is held in a shift register whose MSB is the next bit to send.
    always_comb begin
        case (w_nxt_state)
            TX_ID_A:     w_nxt_bit = r_id_a_sh[10];
            TX_SRR_RTR:  w_nxt_bit = r_ide | r_rtr;
            TX_IDE:      w_nxt_bit = r_ide;
            TX_ID_B:     w_nxt_bit = r_id_b_sh[17];
            TX_RTR:      w_nxt_bit = r_rtr;
            TX_R1, TX_R0: w_nxt_bit = 1'b0;
            TX_DLC:      w_nxt_bit = r_dlc_sh[3];
            TX_DATA:     w_nxt_bit = r_data_sh[63];
            TX_CRC:      w_nxt_bit = (r_state == TX_CRC) ? r_crc_sh[14] : w_crc[14];
            default:     w_nxt_bit = 1'b1;
        endcase
    end

    assign w_start     = (r_state == TX_IDLE) & tx_if.tx_point_i & tx_if.tx_request_i & tx_if.bus_idle_i;
    assign w_stuff_due = (r_state inside {TX_SOF, TX_ID_A, TX_SRR_RTR, TX_IDE, TX_ID_B, TX_RTR,
                                          TX_R1, TX_R0, TX_DLC, TX_DATA, TX_CRC}) && (r_run == STUFF_RUN);
    assign w_do_stuff  = tx_if.tx_point_i & w_stuff_due;
    assign w_advance   = (r_state != TX_IDLE) & tx_if.tx_point_i & ~w_stuff_due;
    assign w_crc_en    = w_start | (w_advance & (w_nxt_state inside {TX_ID_A, TX_SRR_RTR, TX_IDE,
                                     TX_ID_B, TX_RTR, TX_R1, TX_R0, TX_DLC, TX_DATA}));
    assign w_crc_bit   = w_start ? 1'b0 : w_nxt_bit;

    assign w_sample   = tx_if.sample_point_i & (r_state != TX_IDLE);
    assign w_mismatch = tx_if.sampled_bit_i ^ r_tx;
    assign w_in_arb   = r_state inside {TX_ID_A, TX_SRR_RTR, TX_IDE, TX_ID_B, TX_RTR};
    assign w_arb_lost = w_in_arb & ~r_stuff & r_tx & ~tx_if.sampled_bit_i;
    assign w_ack_err  = (r_state == TX_ACK) & tx_if.sampled_bit_i;
    assign w_bit_err  = (r_state != TX_ACK) & w_mismatch & ~w_arb_lost;
    assign w_done     = (r_state == TX_EOF) & (r_cnt == EOF_LAST) & ~w_mismatch;

    can_crc15_gen u_crc (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clear_i  (w_start),
        .enable_i (w_crc_en),
        .bit_i    (w_crc_bit),
        .crc_o    (w_crc)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= TX_IDLE;
            r_cnt     <= 6'd0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_stuff   <= 1'b0;
            r_last    <= 1'b0;
            r_run     <= 4'd0;
            r_ide     <= 1'b0;
            r_rtr     <= 1'b0;
            r_dlc     <= 4'd0;
            r_id_a_sh <= 11'd0;
            r_id_b_sh <= 18'd0;
            r_dlc_sh  <= 4'd0;
            r_data_sh <= 64'd0;
            r_crc_sh  <= 15'd0;
            r_done    <= 1'b0;
            r_arb     <= 1'b0;
            r_bit_err <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_arb     <= 1'b0;
            r_bit_err <= 1'b0;
            r_ack_err <= 1'b0;
            if (w_start) begin
                r_ide     <= tx_if.ide_i;
                r_rtr     <= tx_if.rtr_i;
                r_dlc     <= tx_if.dlc_i;
                r_id_a_sh <= tx_if.ide_i ? tx_if.id_i[28:18] : tx_if.id_i[10:0];
                r_id_b_sh <= tx_if.id_i[17:0];
                r_dlc_sh  <= tx_if.dlc_i;
                r_data_sh <= tx_if.data_i;
                r_state   <= TX_SOF;
                r_cnt     <= 6'd0;
                r_tx      <= 1'b0;
                r_busy    <= 1'b1;
                r_stuff   <= 1'b0;
                r_last    <= 1'b0;
                r_run     <= 4'd1;
            end else if (w_do_stuff) begin
                r_tx    <= ~r_last;
                r_last  <= ~r_last;
                r_run   <= 4'd1;
                r_stuff <= 1'b1;
            end else if (w_advance) begin
                r_state <= w_nxt_state;
                r_cnt   <= w_nxt_cnt;
                r_tx    <= w_nxt_bit;
                r_stuff <= 1'b0;
                if (w_nxt_state inside {TX_ID_A, TX_SRR_RTR, TX_IDE, TX_ID_B, TX_RTR,
                                        TX_R1, TX_R0, TX_DLC, TX_DATA, TX_CRC}) begin
                    r_last <= w_nxt_bit;
                    r_run  <= (w_nxt_bit == r_last) ? r_run + 4'd1 : 4'd1;
                end
                case (w_nxt_state)
                    TX_ID_A: r_id_a_sh <= r_id_a_sh << 1;
                    TX_ID_B: r_id_b_sh <= r_id_b_sh << 1;
                    TX_DLC:  r_dlc_sh  <= r_dlc_sh << 1;
                    TX_DATA: r_data_sh <= r_data_sh << 1;
                    TX_CRC:  r_crc_sh  <= (r_state == TX_CRC) ? (r_crc_sh << 1) : (w_crc << 1);
                    default: ;
                endcase
            end else if (w_sample && (w_arb_lost || w_ack_err || w_bit_err || w_done)) begin
                r_arb     <= w_arb_lost;
                r_ack_err <= w_ack_err;
                r_bit_err <= w_bit_err;
                r_done    <= w_done & ~w_ack_err & ~w_bit_err;
                r_state   <= TX_IDLE;
                r_busy    <= 1'b0;
                r_tx      <= 1'b1;
                r_stuff   <= 1'b0;
            end
        end
    end

    assign tx_if.tx_o       = r_tx;
    assign tx_if.tx_busy_o  = r_busy;
    assign tx_if.tx_done_o  = r_done;
    assign tx_if.arb_lost_o = r_arb;
    assign tx_if.bit_err_o  = r_bit_err;
    assign tx_if.ack_err_o  = r_ack_err;
endmodule

// File: tb/tb_can_frame_tx_fsm.sv
// Table-driven bench for can_frame_tx_fsm: frames are compared bit-for-bit with a stuffing/CRC model.
module tb_can_frame_tx_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    can_frame_tx_fsm_if vif ();

    can_frame_tx_fsm dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .tx_if   (vif.slave)
    );

    typedef struct {
        logic        ide;
        logic        rtr;
        logic [28:0] id;
        logic [3:0]  dlc;
        logic [63:0] data;
        logic        ack_bit;
        int          force_idx;
        logic        force_val;
        int          outcome;   // 0 done, 1 ack error, 2 arbitration lost, 3 bit error
    } vec_t;

    vec_t  vecs[6];
    string names[6];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_done = 0, n_arb = 0, n_biterr = 0, n_ackerr = 0;
    logic  ub_q[$];
    logic  exp_q[$];
    logic  ds_q[$];
    int    exp_len;
    logic  got[0:255];
    int    nbits;

    always @(posedge clk) begin
        if (vif.tx_done_o)  n_done   <= n_done + 1;
        if (vif.arb_lost_o) n_arb    <= n_arb + 1;
        if (vif.bit_err_o)  n_biterr <= n_biterr + 1;
        if (vif.ack_err_o)  n_ackerr <= n_ackerr + 1;
    end

    always @(posedge clk) begin
        assert (!(vif.tx_point_i && vif.sample_point_i))
            else $error("tx_point and sample_point asserted together");
    end

    task automatic chk(input string nm, input longint act, input longint expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic push_field(input logic [63:0] val, input int n);
        logic [63:0] t;
        t = val << (64 - n);
        for (int i = 0; i < n; i++) begin
            ub_q.push_back(t[63]);
            t = t << 1;
        end
    endtask

    task automatic build_exp(input vec_t v);
        logic [14:0] c;
        logic        nb, last;
        int          run, nbytes;
        ub_q.delete();
        exp_q.delete();
        ub_q.push_back(1'b0);
        push_field(v.ide ? 64'(v.id[28:18]) : 64'(v.id[10:0]), 11);
        if (v.ide) begin
            push_field(64'h3, 2);
            push_field(64'(v.id[17:0]), 18);
        end
        push_field(64'({v.rtr, 2'b00}), 3);
        push_field(64'(v.dlc), 4);
        nbytes = v.rtr ? 0 : ((v.dlc > 4'd8) ? 8 : int'(v.dlc));
        push_field(v.data >> (64 - 8 * nbytes), 8 * nbytes);
        c = 15'h0;
        foreach (ub_q[i]) begin
            nb = ub_q[i] ^ c[14];
            c = {c[13:0], 1'b0};
            if (nb) c = c ^ 15'h4599;
        end
        push_field(64'(c), 15);
        run = 0;
        last = 1'b0;
        foreach (ub_q[i]) begin
            exp_q.push_back(ub_q[i]);
            if (run > 0 && ub_q[i] == last) run++;
            else begin run = 1; last = ub_q[i]; end
            if (run == 5) begin
                exp_q.push_back(~last);
                last = ~last;
                run = 1;
            end
        end
        exp_len = exp_q.size();
        repeat (10) exp_q.push_back(1'b1);
    endtask

    task automatic destuff(input int n);
        int   run;
        logic last, skip;
        ds_q.delete();
        run = 0; last = 1'b0; skip = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (skip) begin
                skip = 1'b0; last = got[i]; run = 1;
            end else begin
                ds_q.push_back(got[i]);
                if (run > 0 && got[i] == last) run++;
                else begin run = 1; last = got[i]; end
                if (run == 5) skip = 1'b1;
            end
        end
    endtask

    function automatic int field(input int start, input int len);
        int v;
        v = 0;
        for (int i = 0; i < len; i++) v = (v << 1) | ((start + i < ds_q.size()) ? int'(ds_q[start + i]) : 0);
        return v;
    endfunction

    task automatic run_frame(input vec_t v, input int abort_after, output int nb);
        logic s;
        vif.ide_i = v.ide; vif.rtr_i = v.rtr; vif.id_i = v.id;
        vif.dlc_i = v.dlc; vif.data_i = v.data;
        vif.tx_request_i = 1'b1;
        nb = 0;
        for (int b = 0; b < 200; b++) begin
            @(negedge clk) vif.tx_point_i = 1'b1;
            @(negedge clk) vif.tx_point_i = 1'b0;
            vif.tx_request_i = 1'b0;
            got[b] = vif.tx_o;
            nb = b + 1;
            if (abort_after >= 0 && b >= abort_after && vif.tx_o == 1'b0) return;
            repeat (2) @(negedge clk);
            if (b == v.force_idx)        s = v.force_val;
            else if (b == exp_len + 1)   s = v.ack_bit;
            else                         s = vif.tx_o;
            vif.sampled_bit_i = s;
            vif.sample_point_i = 1'b1;
            @(negedge clk) vif.sample_point_i = 1'b0;
            vif.sampled_bit_i = 1'b1;
            @(negedge clk);
            if (!vif.tx_busy_o) return;
        end
    endtask

    task automatic check_frame(input vec_t v, input string tag);
        int d0, a0, b0, k0, exp_n, mm;
        d0 = n_done; a0 = n_arb; b0 = n_biterr; k0 = n_ackerr;
        build_exp(v);
        run_frame(v, -1, nbits);
        @(negedge clk);
        case (v.outcome)
            0:       exp_n = exp_len + 10;
            1:       exp_n = exp_len + 2;
            default: exp_n = v.force_idx + 1;
        endcase
        mm = -1;
        for (int i = 0; i < nbits; i++)
            if (mm < 0 && i < exp_q.size() && got[i] !== exp_q[i]) mm = i;
        $display("frame %s: %0d bits on bus, done=%0d arb=%0d biterr=%0d ackerr=%0d", tag, nbits,
                 n_done - d0, n_arb - a0, n_biterr - b0, n_ackerr - k0);
        chk({tag, ".bit_count"}, nbits, exp_n);
        chk({tag, ".first_bad_bit"}, mm, -1);
        chk({tag, ".done_pulses"}, n_done - d0, (v.outcome == 0) ? 1 : 0);
        chk({tag, ".ack_err_pulses"}, n_ackerr - k0, (v.outcome == 1) ? 1 : 0);
        chk({tag, ".arb_lost_pulses"}, n_arb - a0, (v.outcome == 2) ? 1 : 0);
        chk({tag, ".bit_err_pulses"}, n_biterr - b0, (v.outcome == 3) ? 1 : 0);
        chk({tag, ".busy_after"}, vif.tx_busy_o, 0);
        chk({tag, ".tx_after"}, vif.tx_o, 1);
    endtask

    initial begin
        vec_t vm;
        vif.tx_point_i = 1'b0; vif.sample_point_i = 1'b0; vif.sampled_bit_i = 1'b1;
        vif.bus_idle_i = 1'b1; vif.tx_request_i = 1'b0; vif.ide_i = 1'b0; vif.rtr_i = 1'b0;
        vif.id_i = '0; vif.dlc_i = '0; vif.data_i = '0;

        //           ide   rtr   id             dlc    data                    ack  fidx fval outcome
        vecs[0] = '{1'b0, 1'b0, 29'h123,      4'd1,  64'hAA00_0000_0000_0000, 1'b0, -1, 1'b0, 0};
        vecs[1] = '{1'b0, 1'b0, 29'h000,      4'd0,  64'h0,                   1'b0, -1, 1'b0, 0};
        vecs[2] = '{1'b0, 1'b0, 29'h7FF,      4'd0,  64'h0,                   1'b0,  4, 1'b0, 2};
        vecs[3] = '{1'b1, 1'b1, 29'h1ABCDEF0, 4'd4,  64'h0,                   1'b0, -1, 1'b0, 0};
        vecs[4] = '{1'b0, 1'b0, 29'h0F0,      4'd15, 64'hFEDC_BA98_7654_3210, 1'b1, -1, 1'b0, 1};
        vecs[5] = '{1'b0, 1'b0, 29'h123,      4'd1,  64'h5500_0000_0000_0000, 1'b0,  0, 1'b1, 3};
        names = '{"base_data", "id_zero", "arb_lost", "ext_remote", "dlc15_ack_err", "sof_bit_err"};

        repeat (3) @(negedge clk);
        chk("reset.tx", vif.tx_o, 1);
        chk("reset.busy", vif.tx_busy_o, 0);
        chk("reset.pulses", {vif.tx_done_o, vif.arb_lost_o, vif.bit_err_o, vif.ack_err_o}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle.tx", vif.tx_o, 1);

        for (int i = 0; i < 6; i++) begin
            check_frame(vecs[i], names[i]);
            if (i == 0) begin
                destuff(nbits - 10);
                chk("base_data.unstuffed_len", ds_q.size(), 42);
                chk("base_data.data_byte", field(19, 8), 'hAA);
            end
            if (i == 1) begin
                chk("id_zero.first12", {got[0], got[1], got[2], got[3], got[4], got[5],
                                        got[6], got[7], got[8], got[9], got[10], got[11]},
                    12'b000001_000001);
            end
            if (i == 3) begin
                destuff(nbits - 10);
                chk("ext_remote.srr_ide", field(12, 2), 3);
                chk("ext_remote.rtr_r1_r0", field(32, 3), 4);
                chk("ext_remote.dlc", field(35, 4), 4);
                chk("ext_remote.unstuffed_len", ds_q.size(), 54);
            end
            if (i == 4) begin
                destuff(nbits - 2);
                chk("dlc15.dlc", field(15, 4), 15);
                chk("dlc15.unstuffed_len", ds_q.size(), 98);
            end
        end

        vm = vecs[0];
        vm.dlc = 4'd8;
        vm.data = 64'h0123_4567_89AB_CDEF;
        build_exp(vm);
        run_frame(vm, 30, nbits);
        chk("midreset.tx_before", vif.tx_o, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset.tx_async", vif.tx_o, 1);
        chk("midreset.busy_async", vif.tx_busy_o, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midreset.idle_busy", vif.tx_busy_o, 0);
        chk("midreset.idle_tx", vif.tx_o, 1);
        check_frame(vecs[0], "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
